// File: rtl/bit_sel_pkg.sv
// Shared constants and helpers for the 32-to-16 bit window selector.
package bit_sel_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int OUT_WIDTH    = 16;
  localparam int CMD_WIDTH    = 5;
  localparam int SHIFT_EN_BIT = 4;

  // Number of power-of-two shifter layers needed to cover shifts 0..16.
  localparam int NUM_STAGES   = 5;

  // Decode the command into a right-shift amount. The +1 is done in 5 bits
  // so code 4'hF yields 16 instead of wrapping to 0.
  function automatic logic [CMD_WIDTH-1:0] shift_amount(input logic [CMD_WIDTH-1:0] cmd);
    logic [CMD_WIDTH-1:0] amt;
    amt = '0;
    if (cmd[SHIFT_EN_BIT]) begin
      amt = {1'b0, cmd[SHIFT_EN_BIT-1:0]} + CMD_WIDTH'(1);
    end
    return amt;
  endfunction

endpackage : bit_sel_pkg

// File: rtl/log_shifter_stage.sv
// One layer of a logarithmic right shifter: passes the input through or
// shifts it right by a fixed power of two, zero-filling from the top.
// OUT_WIDTH may be narrower than IN_WIDTH so the last layer produces only
// the bits that are actually consumed.
module log_shifter_stage #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 32,
  parameter int SHIFT     = 1
) (
  input  logic                 en,
  input  logic [IN_WIDTH-1:0]  d,
  output logic [OUT_WIDTH-1:0] q
);

  // Per output bit: 2:1 mux between the unshifted bit and the bit SHIFT above.
  for (genvar i = 0; i < OUT_WIDTH; i++) begin : g_bit
    if (i + SHIFT < IN_WIDTH) begin : g_src
      assign q[i] = en ? d[i+SHIFT] : d[i];
    end else begin : g_fill
      assign q[i] = en ? 1'b0 : d[i];
    end
  end

endmodule : log_shifter_stage

// File: rtl/bit_sel_window_32to16.sv
// Registered window selector: extracts a 16-bit field from a 32-bit word at
// a right-shift offset of 0 or 1..16, one cycle of latency, no back-pressure.
module bit_sel_window_32to16 #(
  parameter int DATA_WIDTH    = 32,
  parameter int COMMAND_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  input  logic [DATA_WIDTH-1:0]     i_data_bus,
  input  logic                      i_en,
  input  logic [COMMAND_WIDTH-1:0]  i_cmd,
  output logic                      o_valid,
  output logic [DATA_WIDTH/2-1:0]   o_data_bus
);

  import bit_sel_pkg::*;

  logic [CMD_WIDTH-1:0]  shift_amt;
  logic [DATA_WIDTH-1:0] stage_data [NUM_STAGES];
  logic [OUT_WIDTH-1:0]  sel_data;

  logic [OUT_WIDTH-1:0]  data_d, data_q;
  logic                  valid_d, valid_q;

  assign shift_amt     = shift_amount(i_cmd);
  assign stage_data[0] = i_data_bus;

  // Full-width layers shifting by 1, 2, 4 and 8.
  for (genvar s = 0; s < NUM_STAGES - 1; s++) begin : g_stage
    log_shifter_stage #(
      .IN_WIDTH  (DATA_WIDTH),
      .OUT_WIDTH (DATA_WIDTH),
      .SHIFT     (1 << s)
    ) u_stage (
      .en (shift_amt[s]),
      .d  (stage_data[s]),
      .q  (stage_data[s+1])
    );
  end

  // Final layer shifts by 16 and keeps only the 16-bit window; since the
  // shift never exceeds 16 the window never needs fill bits.
  log_shifter_stage #(
    .IN_WIDTH  (DATA_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (1 << (NUM_STAGES - 1))
  ) u_stage_last (
    .en (shift_amt[NUM_STAGES-1]),
    .d  (stage_data[NUM_STAGES-1]),
    .q  (sel_data)
  );

  // Next-state for the output register: load, dummy zero, or hold.
  always_comb begin
    // NOTE: defaults first so every path assigns data_d/valid_d; a missing
    // branch would otherwise infer a latch.
    data_d  = data_q;
    valid_d = 1'b0;
    if (i_en) begin
      if (i_valid) begin
        data_d  = sel_data;
        valid_d = 1'b1;
      end else begin
        data_d  = '0;
      end
    end
  end

  // Output register with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_data_bus = data_q;
  assign o_valid    = valid_q;

endmodule : bit_sel_window_32to16

// File: tb/tb_bit_sel_window_32to16.sv
// Self-checking bench for bit_sel_window_32to16: directed vector table,
// hand-written reset/enable sequences and a randomized model comparison.
module tb_bit_sel_window_32to16;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_data_bus;
  logic        i_en;
  logic [4:0]  i_cmd;
  logic        o_valid;
  logic [15:0] o_data_bus;

  int total = 0;
  int bad   = 0;

  bit_sel_window_32to16 dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .i_en       (i_en),
    .i_cmd      (i_cmd),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        en;
    logic [4:0]  cmd;
    logic [31:0] data;
    logic        exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic e, input logic [4:0] c, input logic [31:0] d);
    i_valid    = v;
    i_en       = e;
    i_cmd      = c;
    i_data_bus = d;
  endtask

  // Inputs change on the falling edge; outputs are checked on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [15:0] ref_sel(input logic [31:0] d, input logic [4:0] c);
    logic [4:0]  s;
    logic [31:0] t;
    s = c[4] ? (5'(c[3:0]) + 5'd1) : 5'd0;
    t = d >> s;
    return t[15:0];
  endfunction

  function automatic vec_t mk(input logic v, input logic e, input logic [4:0] c,
                              input logic [31:0] d, input logic ev, input logic [15:0] ed);
    vec_t r;
    r.valid = v; r.en = e; r.cmd = c; r.data = d; r.exp_valid = ev; r.exp_data = ed;
    return r;
  endfunction

  // Watchdog: the run is a fixed number of cycles, so this only fires on a hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [15:0] sweep_exp [16];
    logic [15:0] model_d;
    logic        model_v;

    sweep_exp = '{16'h0408, 16'h8204, 16'h4102, 16'h2081,
                  16'h1040, 16'h0820, 16'h8410, 16'h4208,
                  16'h2104, 16'h1082, 16'h8841, 16'h4420,
                  16'h2210, 16'h9108, 16'h4884, 16'hA442};

    // Shift sweep: S = 1..16 on consecutive cycles.
    for (int k = 0; k < 16; k++) begin
      vecs.push_back(mk(1'b1, 1'b1, 5'b10000 | 5'(k), 32'hA4420810, 1'b1, sweep_exp[k]));
    end
    // No shift regardless of the low command bits.
    vecs.push_back(mk(1'b1, 1'b1, 5'b00000, 32'hA4420810, 1'b1, 16'h0810));
    vecs.push_back(mk(1'b1, 1'b1, 5'b00101, 32'hA4420810, 1'b1, 16'h0810));
    vecs.push_back(mk(1'b1, 1'b1, 5'b01111, 32'hA4420810, 1'b1, 16'h0810));
    // Valid gating gives dummy zero data.
    vecs.push_back(mk(1'b0, 1'b1, 5'b10001, 32'hA4420810, 1'b0, 16'h0000));
    // Enable hold: load, hold for three cycles under changing inputs, resume.
    vecs.push_back(mk(1'b1, 1'b1, 5'b10001, 32'hA4420810, 1'b1, 16'h8204));
    vecs.push_back(mk(1'b1, 1'b0, 5'b11111, 32'hFFFFFFFF, 1'b0, 16'h8204));
    vecs.push_back(mk(1'b0, 1'b0, 5'b00000, 32'h12345678, 1'b0, 16'h8204));
    vecs.push_back(mk(1'b1, 1'b0, 5'b10111, 32'hDEADBEEF, 1'b0, 16'h8204));
    vecs.push_back(mk(1'b1, 1'b1, 5'b11111, 32'h12345678, 1'b1, 16'h1234));
    vecs.push_back(mk(1'b1, 1'b1, 5'b10111, 32'hDEADBEEF, 1'b1, 16'hADBE));

    // Reset held with valid traffic present.
    rst = 1'b0;
    drive(1'b1, 1'b1, 5'b10000, 32'hA4420810);
    repeat (3) step();
    check("reset_hold_data", 32'(o_data_bus), 32'h0);
    check("reset_hold_valid", 32'(o_valid), 32'h0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].en, vecs[i].cmd, vecs[i].data);
      step();
      check($sformatf("vec%0d_data", i), 32'(o_data_bus), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(vecs[i].exp_valid));
    end

    // Asynchronous reset between edges clears outputs without a clock edge.
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_data", 32'(o_data_bus), 32'h0);
    check("async_rst_valid", 32'(o_valid), 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'b10100, 32'hA4420810);
    step();
    check("rst_low_edge_data", 32'(o_data_bus), 32'h0);
    check("rst_low_edge_valid", 32'(o_valid), 32'h0);
    // First edge after release samples normally.
    rst = 1'b1;
    drive(1'b1, 1'b1, 5'b10000, 32'hA4420810);
    step();
    check("post_rst_data", 32'(o_data_bus), 32'h0408);
    check("post_rst_valid", 32'(o_valid), 32'h1);

    // Randomized comparison against a simple behavioral model.
    model_d = 16'h0408;
    for (int n = 0; n < 1000; n++) begin
      logic        v, e;
      logic [4:0]  c;
      logic [31:0] d;
      v = 1'($urandom_range(0, 3) != 0);
      e = 1'($urandom_range(0, 4) != 0);
      c = 5'($urandom);
      d = $urandom;
      drive(v, e, c, d);
      if (e) begin
        model_d = v ? ref_sel(d, c) : 16'h0000;
        model_v = v;
      end else begin
        model_v = 1'b0;
      end
      step();
      check($sformatf("rand%0d_data", n), 32'(o_data_bus), 32'(model_d));
      check($sformatf("rand%0d_valid", n), 32'(o_valid), 32'(model_v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bit_sel_window_32to16
